// File: rtl/ball_pkg.sv
// Shared projectile constants: gun placement, play-field bounds, direction codes
// and the muzzle spawn position used by the ball manager and the display stage.
package ball_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_UP    = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_e;

   localparam int X_W = 8;
   localparam int Y_W = 7;

   localparam int GUN_X  = 80;
   localparam int GUN_Y  = 60;
   localparam int MUZZLE = 6;

   localparam int FIELD_X_MIN = 10;
   localparam int FIELD_X_MAX = 150;
   localparam int FIELD_Y_MIN = 10;
   localparam int FIELD_Y_MAX = 110;

   // (0,0) is outside the play area, so a parked slot is never drawn.
   localparam int PARK_X = 0;
   localparam int PARK_Y = 0;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pos_t;

   function automatic pos_t spawn_pos(input dir_e dir);
      pos_t p;
      p.x = X_W'(GUN_X);
      p.y = Y_W'(GUN_Y);
      case (dir)
         DIR_RIGHT: p.x = X_W'(GUN_X + MUZZLE);
         DIR_UP:    p.y = Y_W'(GUN_Y - MUZZLE);
         DIR_LEFT:  p.x = X_W'(GUN_X - MUZZLE);
         default:   p.y = Y_W'(GUN_Y + MUZZLE);
      endcase
      return p;
   endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// Game-side bus of the ball manager: play/fire controls and hit pulses in,
// packed ball positions, live mask and refused-fire pulse out.
interface ball_ctrl_if #(
   parameter int NUM_BALLS = 8
);
   logic                   game_active;
   logic                   fire;
   logic [1:0]             gun_dir;
   logic [NUM_BALLS-1:0]   hit_clear;
   logic [8*NUM_BALLS-1:0] ball_x_vector;
   logic [7*NUM_BALLS-1:0] ball_y_vector;
   logic [NUM_BALLS-1:0]   ball_valid;
   logic                   fire_drop;

   modport master (
      output game_active, fire, gun_dir, hit_clear,
      input  ball_x_vector, ball_y_vector, ball_valid, fire_drop
   );

   modport slave (
      input  game_active, fire, gun_dir, hit_clear,
      output ball_x_vector, ball_y_vector, ball_valid, fire_drop
   );
endinterface

// File: rtl/ball_slot.sv
// One ball slot: holds live flag, direction and position; steps on tick and
// parks itself when the step would leave the play field.
module ball_slot
   import ball_pkg::*;
#(
   parameter int STEP = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load,
   input  dir_e           load_dir,
   input  logic [X_W-1:0] load_x,
   input  logic [Y_W-1:0] load_y,
   input  logic           tick,
   input  logic           clear,
   output logic           valid,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y
);

   dir_e       dir;
   logic [8:0] next_x;
   logic [8:0] next_y;
   logic       off_field;

   // 9-bit arithmetic: a step below zero wraps to a large value and fails the max bound.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch behind.
      next_x = {1'b0, x};
      next_y = {2'b00, y};
      case (dir)
         DIR_RIGHT: next_x = {1'b0, x} + 9'(STEP);
         DIR_UP:    next_y = {2'b00, y} - 9'(STEP);
         DIR_LEFT:  next_x = {1'b0, x} - 9'(STEP);
         default:   next_y = {2'b00, y} + 9'(STEP);
      endcase
      off_field = (next_x < 9'(FIELD_X_MIN)) || (next_x > 9'(FIELD_X_MAX)) ||
                  (next_y < 9'(FIELD_Y_MIN)) || (next_y > 9'(FIELD_Y_MAX));
   end

   // Priority: clear > load > tick move.
   always_ff @(posedge clock) begin
      // NOTE: state uses non-blocking assignments so every slot samples pre-edge values.
      if (reset || clear) begin
         valid <= 1'b0;
         dir   <= DIR_RIGHT;
         x     <= X_W'(PARK_X);
         y     <= Y_W'(PARK_Y);
      end else if (load) begin
         valid <= 1'b1;
         dir   <= load_dir;
         x     <= load_x;
         y     <= load_y;
      end else if (tick && valid) begin
         if (off_field) begin
            valid <= 1'b0;
            x     <= X_W'(PARK_X);
            y     <= Y_W'(PARK_Y);
         end else begin
            x <= next_x[X_W-1:0];
            y <= next_y[Y_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ball_ctrl.sv
// Projectile manager: game tick divider, fire edge detect, lowest-free-slot
// allocation and packing of the slot positions for the display stage.
module ball_ctrl
   import ball_pkg::*;
#(
   parameter int NUM_BALLS = 8,
   parameter int TICK_DIV  = 833333,
   parameter int STEP      = 1
) (
   input logic        clock,
   input logic        reset,
   ball_ctrl_if.slave bus
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0]       tick_cnt;
   logic                   tick;
   logic                   fire_q;
   logic                   fire_req;
   logic                   fire_drop_q;
   logic [NUM_BALLS-1:0]   valid;
   logic [NUM_BALLS-1:0]   free;
   logic [NUM_BALLS-1:0]   load_sel;
   logic [NUM_BALLS-1:0]   load;
   logic [NUM_BALLS-1:0]   clear;
   logic [X_W-1:0]         slot_x [NUM_BALLS];
   logic [Y_W-1:0]         slot_y [NUM_BALLS];
   logic [8*NUM_BALLS-1:0] x_vec;
   logic [7*NUM_BALLS-1:0] y_vec;
   pos_t                   spawn;

   assign tick = bus.game_active && (tick_cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clock) begin
      if (reset || !bus.game_active) begin
         tick_cnt    <= '0;
         fire_q      <= 1'b0;
         fire_drop_q <= 1'b0;
      end else begin
         tick_cnt    <= tick ? '0 : tick_cnt + CNT_W'(1);
         fire_q      <= bus.fire;
         fire_drop_q <= fire_req && (&valid);
      end
   end

   assign fire_req = bus.game_active && bus.fire && !fire_q;

   // Lowest free slot, isolated with x & -x on the registered live mask.
   assign free     = ~valid;
   assign load_sel = free & (~free + NUM_BALLS'(1));
   assign load     = fire_req ? load_sel : '0;

   // A hit on a dead slot is ignored so it cannot cancel a same-cycle allocation.
   assign clear = {NUM_BALLS{!bus.game_active}} | (bus.hit_clear & valid);

   assign spawn = spawn_pos(dir_e'(bus.gun_dir));

   for (genvar i = 0; i < NUM_BALLS; i++) begin : g_slot
      ball_slot #(
         .STEP(STEP)
      ) u_slot (
         .clock   (clock),
         .reset   (reset),
         .load    (load[i]),
         .load_dir(dir_e'(bus.gun_dir)),
         .load_x  (spawn.x),
         .load_y  (spawn.y),
         .tick    (tick),
         .clear   (clear[i]),
         .valid   (valid[i]),
         .x       (slot_x[i]),
         .y       (slot_y[i])
      );
   end

   // Slot 0 occupies the most significant field of each bus.
   always_comb begin
      x_vec = '0;
      y_vec = '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
         x_vec[X_W*(NUM_BALLS-i)-1 -: X_W] = slot_x[i];
         y_vec[Y_W*(NUM_BALLS-i)-1 -: Y_W] = slot_y[i];
      end
   end

   assign bus.ball_x_vector = x_vec;
   assign bus.ball_y_vector = y_vec;
   assign bus.ball_valid    = valid;
   assign bus.fire_drop     = fire_drop_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed vector table, hand-written multi-cycle sequences
// and random play, all compared against an integer-arithmetic game model.
module tb_ball_ctrl;

   localparam int NB = 8;
   localparam int TD = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   ball_ctrl_if #(.NUM_BALLS(NB)) bus ();

   ball_ctrl #(
      .NUM_BALLS(NB),
      .TICK_DIV (TD),
      .STEP     (1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Model state: plain integers per slot, game rules applied directly.
   int m_valid [NB];
   int m_x     [NB];
   int m_y     [NB];
   int m_cnt  = 0;
   int m_fq   = 0;
   int m_drop = 0;
   int m_dx   [NB];
   int m_dy   [NB];

   typedef struct {
      logic       rst;
      logic       ga;
      logic       fire;
      logic [1:0] dir;
      logic [7:0] hit;
      logic [7:0] exp_valid;
      logic       exp_drop;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic void park(input int i);
      m_valid[i] = 0;
      m_x[i]     = 0;
      m_y[i]     = 0;
   endfunction

   function automatic void model_update();
      int  free_slot;
      bit  tick;
      bit  req;
      int  nx;
      int  ny;
      if (reset || !bus.game_active) begin
         for (int i = 0; i < NB; i++) park(i);
         m_cnt  = 0;
         m_fq   = 0;
         m_drop = 0;
         return;
      end
      tick      = (m_cnt == TD - 1);
      req       = bus.fire && (m_fq == 0);
      free_slot = -1;
      for (int i = NB - 1; i >= 0; i--)
         if (m_valid[i] == 0) free_slot = i;
      for (int i = 0; i < NB; i++) begin
         if (bus.hit_clear[i] && m_valid[i] != 0) begin
            park(i);
         end else if (req && i == free_slot) begin
            m_valid[i] = 1;
            m_dx[i] = 0;
            m_dy[i] = 0;
            case (bus.gun_dir)
               2'd0: m_dx[i] = 1;
               2'd1: m_dy[i] = -1;
               2'd2: m_dx[i] = -1;
               default: m_dy[i] = 1;
            endcase
            m_x[i] = 80 + 6 * m_dx[i];
            m_y[i] = 60 + 6 * m_dy[i];
         end else if (tick && m_valid[i] != 0) begin
            nx = m_x[i] + m_dx[i];
            ny = m_y[i] + m_dy[i];
            if (nx < 10 || nx > 150 || ny < 10 || ny > 110) park(i);
            else begin
               m_x[i] = nx;
               m_y[i] = ny;
            end
         end
      end
      m_drop = (req && free_slot < 0) ? 1 : 0;
      m_cnt  = tick ? 0 : m_cnt + 1;
      m_fq   = bus.fire ? 1 : 0;
   endfunction

   task automatic compare_model();
      logic [63:0] ex;
      logic [55:0] ey;
      logic [7:0]  ev;
      ex = '0;
      ey = '0;
      ev = '0;
      for (int i = 0; i < NB; i++) begin
         ex[63-8*i -: 8] = 8'(m_x[i]);
         ey[55-7*i -: 7] = 7'(m_y[i]);
         ev[i]           = (m_valid[i] != 0);
      end
      check("model_valid", 64'(bus.ball_valid), 64'(ev));
      check("model_drop", 64'(bus.fire_drop), 64'(m_drop));
      check("model_x_vector", bus.ball_x_vector, ex);
      check("model_y_vector", 64'(bus.ball_y_vector), 64'(ey));
   endtask

   task automatic drive(input logic rst, input logic ga, input logic f,
                        input logic [1:0] d, input logic [7:0] hit);
      reset           = rst;
      bus.game_active = ga;
      bus.fire        = f;
      bus.gun_dir     = d;
      bus.hit_clear   = hit;
      @(posedge clock);
      model_update();
      #1;
      compare_model();
   endtask

   function automatic void add(input logic rst, input logic ga, input logic f,
                               input logic [1:0] d, input logic [7:0] hit,
                               input logic [7:0] ev, input logic ed);
      vecs.push_back('{rst, ga, f, d, hit, ev, ed});
   endfunction

   initial begin
      logic [7:0] acc;
      for (int i = 0; i < NB; i++) begin
         park(i);
         m_dx[i] = 0;
         m_dy[i] = 0;
      end
      bus.game_active = 1'b1;
      bus.fire        = 1'b0;
      bus.gun_dir     = 2'd0;
      bus.hit_clear   = '0;

      // Reset with fire toggling, eight spawns, a held button, a refused ninth request,
      // hit-and-fire collision, hit on a dead slot, then a flush.
      add(1, 1, 1, 0, 8'h00, 8'h00, 0);
      add(1, 1, 0, 0, 8'h00, 8'h00, 0);
      add(1, 1, 1, 0, 8'h00, 8'h00, 0);
      add(0, 1, 0, 0, 8'h00, 8'h00, 0);
      acc = 8'h00;
      for (int k = 0; k < 8; k++) begin
         acc = {acc[6:0], 1'b1};
         add(0, 1, 1, 2'(k), 8'h00, acc, 0);
         if (k == 0) add(0, 1, 1, 2'd0, 8'h00, acc, 0);
         add(0, 1, 0, 2'(k), 8'h00, acc, 0);
      end
      add(0, 1, 1, 0, 8'h00, 8'hFF, 1);
      add(0, 1, 1, 0, 8'h00, 8'hFF, 0);
      add(0, 1, 0, 0, 8'h00, 8'hFF, 0);
      add(0, 1, 1, 0, 8'h04, 8'hFB, 1);
      add(0, 1, 0, 0, 8'h00, 8'hFB, 0);
      add(0, 1, 1, 0, 8'h00, 8'hFF, 0);
      add(0, 1, 0, 0, 8'h81, 8'h7E, 0);
      add(0, 1, 0, 0, 8'h01, 8'h7E, 0);
      add(0, 1, 1, 0, 8'h01, 8'h7F, 0);
      add(0, 0, 0, 0, 8'h00, 8'h00, 0);
      add(0, 0, 1, 0, 8'h00, 8'h00, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ga, vecs[i].fire, vecs[i].dir, vecs[i].hit);
         check($sformatf("tbl%0d_valid", i), 64'(bus.ball_valid), 64'(vecs[i].exp_valid));
         check($sformatf("tbl%0d_drop", i), 64'(bus.fire_drop), 64'(vecs[i].exp_drop));
      end

      // Rightward spawn at the muzzle, then three ticks of travel.
      drive(1, 1, 0, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00);
      drive(0, 1, 1, 0, 8'h00);
      check("spawn_valid", 64'(bus.ball_valid), 64'h01);
      check("spawn_x", 64'(bus.ball_x_vector[63:56]), 64'd86);
      check("spawn_y", 64'(bus.ball_y_vector[55:49]), 64'd60);
      for (int c = 0; c < 3 * TD; c++) drive(0, 1, 0, 0, 8'h00);
      check("move3_x", 64'(bus.ball_x_vector[63:56]), 64'd89);

      // Leftward ball runs to the field edge and retires on the following tick.
      drive(1, 1, 0, 2, 8'h00);
      drive(0, 1, 0, 2, 8'h00);
      drive(0, 1, 1, 2, 8'h00);
      check("left_spawn_x", 64'(bus.ball_x_vector[63:56]), 64'd74);
      for (int c = 0; c < 64 * TD; c++) drive(0, 1, 0, 2, 8'h00);
      check("edge_x", 64'(bus.ball_x_vector[63:56]), 64'd10);
      check("edge_valid", 64'(bus.ball_valid), 64'h01);
      for (int c = 0; c < TD; c++) drive(0, 1, 0, 2, 8'h00);
      check("retire_valid", 64'(bus.ball_valid), 64'h00);
      check("retire_x", 64'(bus.ball_x_vector[63:56]), 64'd0);
      check("retire_y", 64'(bus.ball_y_vector[55:49]), 64'd0);

      // Flush on game_active fall, then the tick counter restarts from zero.
      drive(1, 1, 0, 0, 8'h00);
      drive(0, 1, 1, 0, 8'h00);
      drive(0, 1, 0, 1, 8'h00);
      drive(0, 1, 1, 1, 8'h00);
      drive(0, 1, 0, 3, 8'h00);
      drive(0, 1, 1, 3, 8'h00);
      check("three_live", 64'(bus.ball_valid), 64'h07);
      drive(0, 0, 1, 0, 8'h00);
      check("flush_valid", 64'(bus.ball_valid), 64'h00);
      check("flush_x", bus.ball_x_vector, 64'h0);
      check("flush_y", 64'(bus.ball_y_vector), 64'h0);
      check("flush_drop", 64'(bus.fire_drop), 64'h0);
      for (int c = 0; c < 3; c++) drive(0, 0, 0, 0, 8'h00);
      drive(0, 1, 1, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00);
      check("held_cnt_x", 64'(bus.ball_x_vector[63:56]), 64'd86);
      drive(0, 1, 0, 0, 8'h00);
      check("first_tick_x", 64'(bus.ball_x_vector[63:56]), 64'd87);

      // Random play against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] hit;
         for (int b = 0; b < NB; b++) hit[b] = ($urandom_range(0, 63) == 0);
         drive($urandom_range(0, 499) == 0, $urandom_range(0, 399) != 0,
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), hit);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
